uart_tx_frame: RTL and testbench

Parametrised UART transmitter. Successor to the fixed 8-bit shift-out/baud pair.
- Accepts words over a valid/ready handshake.
- Frames each word as: start bit, DATA_BITS data bits LSB-first, optional parity bit, then STOP_BITS stop bits.
- Drives the serial line using an internal frame-aligned bit-period counter.
- Sits between the host-side byte source and the tx pad.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_bit_timer.sv | 28 ++
 rtl/uart_tx_frame.sv | 140 ++++++++++++++
 tb/tb_uart_tx_frame.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, line levels and the parity helper.
// Purely declarative; no latency or backpressure of its own.
// Reused by uart_tx_frame and the future receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;
  localparam logic UART_STOP_LEVEL  = 1'b1;

  // Narrower words are zero-extended by the caller, which leaves the XOR unchanged.
  function automatic logic uart_parity(input logic [8:0] word, input logic odd);
    return (^word) ^ odd;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: baud pulses in the last cycle of every CLKS_PER_BIT-cycle period.
// Latency: clr restarts the period on the next cycle; baud is combinational on the count.
// No backpressure: counts whenever en is high, holds when low.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16,
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  output logic          baud,
  output logic [CW-1:0] count
);

  assign baud = en && (count == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= baud ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start, DATA_BITS LSB-first, optional parity (UART_TX_PARITY_EN), STOP_BITS stops.
// Latency: tx falls one cycle after the accepting edge; frames can run back to back.
// Backpressure: in_ready only in IDLE and in the last cycle of the last stop bit.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int CNT_W        = $clog2(DATA_BITS + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 baud,
  output logic [CNT_W-1:0]     bit_count,
  output logic                 start
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_frame: DATA_BITS must be 5..9");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx_frame: CLKS_PER_BIT must be >= 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity_odd
    $error("uart_tx_frame: PARITY_ODD must be 0 or 1");
  end

  uart_state_t          state, next_state;
  logic [DATA_BITS-1:0] shreg;
  logic                 stop_cnt;
  logic                 active;
  logic                 accept;
  logic                 last_stop;
  logic                 last_data;
  logic [TW-1:0]        tick;
`ifdef UART_TX_PARITY_EN
  logic                 par_bit;
`endif

  assign active    = (state != IDLE);
  assign accept    = in_valid && in_ready;
  assign last_stop = (stop_cnt == 1'(STOP_BITS - 1));
  assign last_data = (bit_count == CNT_W'(DATA_BITS - 1));

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (accept),
    .en    (active),
    .baud  (baud),
    .count (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:   if (accept) next_state = START;
      START:  if (baud) next_state = DATA;
`ifdef UART_TX_PARITY_EN
      DATA:   if (baud && last_data) next_state = PARITY;
`else
      DATA:   if (baud && last_data) next_state = STOP;
`endif
      PARITY: if (baud) next_state = STOP;
      STOP:   if (baud && last_stop) next_state = accept ? START : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    tx       = UART_IDLE_LEVEL;
    busy     = active;
    start    = 1'b0;
    in_ready = (state == IDLE) || ((state == STOP) && baud && last_stop);
    case (state)
      START: begin
        tx    = UART_START_LEVEL;
        start = (tick == '0);
      end
      DATA:   tx = shreg[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx = par_bit;
`endif
      STOP:   tx = UART_STOP_LEVEL;
      default: tx = UART_IDLE_LEVEL;
    endcase
  end

  // bit_count doubles as the data-bit index and holds DATA_BITS until the frame ends.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg     <= '0;
      bit_count <= '0;
      stop_cnt  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else if (accept) begin
      shreg     <= data;
      bit_count <= '0;
      stop_cnt  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_bit   <= uart_parity(9'(data), PARITY_ODD != 0);
`endif
    end else if (baud) begin
      case (state)
        DATA: begin
          shreg     <= shreg >> 1;
          bit_count <= bit_count + 1'b1;
        end
        STOP: begin
          if (last_stop) bit_count <= '0;
          else           stop_cnt  <= stop_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: an 8N1 instance and a 5-bit, 2-stop, odd-parity instance,
// each compared cycle by cycle against a frame-level bit-list model.
module tb_uart_tx_frame;

  localparam int CPB0 = 4;
  localparam int CPB1 = 3;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int N0 = 1 + 8 + PAR + 1;
  localparam int N1 = 1 + 5 + PAR + 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data0;
  logic       valid0, ready0, tx0, busy0, baud0, start0;
  logic [3:0] bc0;
  logic [4:0] data1;
  logic       valid1, ready1, tx1, busy1, baud1, start1;
  logic [2:0] bc1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_tx_frame #(.DATA_BITS(8), .CLKS_PER_BIT(CPB0), .STOP_BITS(1), .PARITY_ODD(0)) dut0 (
    .clk(clk), .reset(rst_n), .data(data0), .in_valid(valid0), .in_ready(ready0),
    .tx(tx0), .busy(busy0), .baud(baud0), .bit_count(bc0), .start(start0)
  );

  uart_tx_frame #(.DATA_BITS(5), .CLKS_PER_BIT(CPB1), .STOP_BITS(2), .PARITY_ODD(1)) dut1 (
    .clk(clk), .reset(rst_n), .data(data1), .in_valid(valid1), .in_ready(ready1),
    .tx(tx1), .busy(busy1), .baud(baud1), .bit_count(bc1), .start(start1)
  );

  // Expected {tx, busy, start, baud, in_ready, bit_count[3:0]} in cycle c of a frame.
  function automatic logic [8:0] model(input logic [8:0] w, input int db, input int cpb,
                                       input int sb, input logic odd, input int c);
    int   b, bc, n;
    logic t, par;
    n   = 1 + db + PAR + sb;
    b   = c / cpb;
    par = odd;
    for (int i = 0; i < db; i++) par ^= w[i];
    if (b == 0)                          t = 1'b0;
    else if (b <= db)                    t = w[b-1];
    else if (PAR == 1 && b == db + 1)    t = par;
    else                                 t = 1'b1;
    bc = (b <= 1) ? 0 : ((b - 1 > db) ? db : b - 1);
    return {t, 1'b1, c == 0, (c % cpb) == cpb - 1, c == n * cpb - 1, 4'(bc)};
  endfunction

  task automatic test_reset();
    logic [8:0] got;
    rst_n = 1'b0; valid0 = 1'b0; valid1 = 1'b0; data0 = '0; data1 = '0;
    #12;
    got = {tx0, ready0, busy0, baud0, start0, bc0};
    n_cmp++;
    if (got !== 9'b1_1000_0000) begin
      n_bad++; $display("FAIL reset0: got %b want %b", got, 9'b1_1000_0000);
    end
    got = {tx1, ready1, busy1, baud1, start1, 1'b0, bc1};
    n_cmp++;
    if (got !== 9'b1_1000_0000) begin
      n_bad++; $display("FAIL reset1: got %b want %b", got, 9'b1_1000_0000);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_frame0(input logic [7:0] w, input logic inject);
    logic [8:0] got, exp;
    int         bauds;
    logic       stray;
    @(negedge clk); data0 = w; valid0 = 1'b1;
    n_cmp++;
    if (ready0 !== 1'b1) begin n_bad++; $display("FAIL ready0_idle: got %b want 1", ready0); end
    @(negedge clk); valid0 = 1'b0;
    bauds = 0;
    for (int c = 0; c < N0 * CPB0; c++) begin
      got = {tx0, busy0, start0, baud0, ready0, bc0};
      exp = model(9'(w), 8, CPB0, 1, 1'b0, c);
      n_cmp++;
      if (got !== exp) begin
        n_bad++; $display("FAIL frame0 w=%h cyc=%0d: got %b want %b", w, c, got, exp);
      end
      bauds += int'(baud0);
      if (inject && c == 2 * CPB0 + 1) begin valid0 = 1'b1; data0 = 8'h12; end
      if (inject && c == 2 * CPB0 + 2) valid0 = 1'b0;
      @(negedge clk);
    end
    n_cmp++;
    if (bauds != N0) begin n_bad++; $display("FAIL baud_count0: got %0d want %0d", bauds, N0); end
    stray = 1'b0;
    repeat (2 * CPB0) begin
      stray |= busy0 | ~tx0;
      @(negedge clk);
    end
    n_cmp++;
    if (stray !== 1'b0) begin n_bad++; $display("FAIL idle_after0 w=%h: got %b want 0", w, stray); end
  endtask

  task automatic test_frame1(input logic [4:0] w);
    logic [8:0] got, exp;
    @(negedge clk); data1 = w; valid1 = 1'b1;
    @(negedge clk); valid1 = 1'b0;
    for (int c = 0; c < N1 * CPB1; c++) begin
      got = {tx1, busy1, start1, baud1, ready1, 1'b0, bc1};
      exp = model(9'(w), 5, CPB1, 2, 1'b1, c);
      n_cmp++;
      if (got !== exp) begin
        n_bad++; $display("FAIL frame1 w=%h cyc=%0d: got %b want %b", w, c, got, exp);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (busy1 !== 1'b0 || tx1 !== 1'b1) begin
      n_bad++; $display("FAIL idle_after1 w=%h: got busy=%b tx=%b want busy=0 tx=1", w, busy1, tx1);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w [2];
    logic [8:0] got, exp;
    w[0] = 8'hA3; w[1] = 8'h0F;
    @(negedge clk); data0 = w[0]; valid0 = 1'b1;
    @(negedge clk);
    for (int f = 0; f < 2; f++) begin
      for (int c = 0; c < N0 * CPB0; c++) begin
        got = {tx0, busy0, start0, baud0, ready0, bc0};
        exp = model(9'(w[f]), 8, CPB0, 1, 1'b0, c);
        n_cmp++;
        if (got !== exp) begin
          n_bad++; $display("FAIL b2b f=%0d cyc=%0d: got %b want %b", f, c, got, exp);
        end
        if (f == 0 && c == 0) data0 = w[1];
        if (f == 1 && c == 0) valid0 = 1'b0;
        @(negedge clk);
      end
    end
    n_cmp++;
    if (busy0 !== 1'b0 || tx0 !== 1'b1) begin
      n_bad++; $display("FAIL b2b_idle: got busy=%b tx=%b want busy=0 tx=1", busy0, tx0);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [8:0] got;
    @(negedge clk); data0 = 8'h00; valid0 = 1'b1;
    @(negedge clk); valid0 = 1'b0;
    repeat (4 * CPB0 + 1) @(negedge clk);
    n_cmp++;
    if (tx0 !== 1'b0 || busy0 !== 1'b1 || bc0 !== 4'd3) begin
      n_bad++; $display("FAIL mid_data: got tx=%b busy=%b bc=%0d want tx=0 busy=1 bc=3", tx0, busy0, bc0);
    end
    #2 rst_n = 1'b0;
    #1;
    got = {tx0, busy0, ready0, baud0, start0, bc0};
    n_cmp++;
    if (got !== 9'b1_0100_0000) begin
      n_bad++; $display("FAIL async_reset: got %b want %b", got, 9'b1_0100_0000);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_frame0(8'h55, 1'b0);
    test_back_to_back();
    test_frame0(8'h07, 1'b0);
    test_frame1(5'h1F);
    test_frame1(5'h07);
    test_frame0(8'($urandom), 1'b1);
    repeat (4) test_frame0(8'($urandom), 1'b0);
    repeat (3) test_frame1(5'($urandom));
    test_reset_mid_frame();
    test_frame0(8'hFF, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
